// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA control block: raw_type encodings, config
// register addresses, controller state enum and a saturating counter helper.
package cfa_pkg;

  localparam logic [1:0] RAW_BGGR = 2'd0;
  localparam logic [1:0] RAW_RGGB = 2'd1;
  localparam logic [1:0] RAW_GBRG = 2'd2;
  localparam logic [1:0] RAW_GRBG = 2'd3;

  localparam logic [1:0] CFG_ADDR_RAW_TYPE = 2'd0;
  localparam logic [1:0] CFG_ADDR_BYPASS   = 2'd1;
  localparam logic [1:0] CFG_ADDR_EXP_H    = 2'd2;
  localparam logic [1:0] CFG_ADDR_ERR_CLR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_LINE      = 2'd2
  } cfa_state_e;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : (v + 12'd1);
  endfunction

endpackage

// File: rtl/cfa_ctrl_if.sv
// Host configuration write channel (valid/ready with 2-bit address, 16-bit data).
interface cfa_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;

  modport master (output cfg_valid, output cfg_addr, output cfg_wdata, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_wdata, output cfg_ready);
endinterface

// File: rtl/cfa_timing_mon.sv
// Sensor timing monitor: vsync/hsync edge detection plus 12-bit saturating
// pixel and line counters gated by the controller state.
module cfa_timing_mon
  import cfa_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_vsync,
  input  logic        in_hsync,
  input  logic        in_den,
  input  cfa_state_e  state,
  output logic        vs_rise,
  output logic        vs_fall,
  output logic        hs_rise,
  output logic        hs_fall,
  output logic [11:0] pix_cnt,
  output logic [11:0] line_cnt
);

  logic        vs_q;
  logic        hs_q;
  logic [11:0] pix_q, pix_d;
  logic [11:0] line_q, line_d;

  assign vs_rise  = in_vsync & ~vs_q;
  assign vs_fall  = ~in_vsync & vs_q;
  assign hs_rise  = in_hsync & ~hs_q;
  assign hs_fall  = ~in_hsync & hs_q;
  assign pix_cnt  = pix_q;
  assign line_cnt = line_q;

  // Counters only move inside a frame; activity while idle is ignored.
  always_comb begin
    pix_d  = pix_q;
    line_d = line_q;
    if ((state == ST_WAIT_LINE) && hs_rise) begin
      pix_d = 12'd0;
    end else if ((state == ST_LINE) && in_den) begin
      pix_d = sat_inc12(pix_q);
    end else begin
      pix_d = pix_q;
    end
    if ((state == ST_IDLE) && vs_rise) begin
      line_d = 12'd0;
    end else if ((state == ST_LINE) && hs_fall && !vs_fall) begin
      line_d = sat_inc12(line_q);
    end else begin
      line_d = line_q;
    end
  end

  // vs_q resets high so a vsync already asserted at release is not a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q   <= 1'b1;
      hs_q   <= 1'b0;
      pix_q  <= 12'd0;
      line_q <= 12'd0;
    end else begin
      vs_q   <= in_vsync;
      hs_q   <= in_hsync;
      pix_q  <= pix_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/cfa_ctrl.sv
// CFA controller: shadowed host config committed at frame start, frame/line
// timing FSM with sticky error flags. Optional counters under CFA_CTRL_STATS_EN.
module cfa_ctrl
  import cfa_pkg::*;
#(
  parameter int SOURCE_H      = 1024,
  parameter int SOURCE_V      = 1024,
  parameter int RAW_TYPE_INIT = 0
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_vsync,
  input  logic        in_hsync,
  input  logic        in_den,
  cfa_ctrl_if.slave   cfg,
  output logic [1:0]  cfa_raw_type,
  output logic        cfa_bypass,
  output logic        frame_start,
  output logic        frame_done,
  output logic        err_hlen,
  output logic        err_vlen,
  output logic        err_trunc,
  output logic        busy
`ifdef CFA_CTRL_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [1:0]  RAW_INIT   = (RAW_TYPE_INIT == 1) ? RAW_RGGB :
                                       (RAW_TYPE_INIT == 2) ? RAW_GBRG :
                                       (RAW_TYPE_INIT == 3) ? RAW_GRBG : RAW_BGGR;
  localparam logic [11:0] EXP_H_INIT = 12'(SOURCE_H);
  localparam logic [11:0] LINES_EXP  = 12'(SOURCE_V);

  cfa_state_e  state_q, state_d;
  logic [1:0]  raw_q, raw_d, sh_raw_q, sh_raw_d;
  logic        byp_q, byp_d, sh_byp_q, sh_byp_d;
  logic [11:0] exp_h_q, exp_h_d, sh_exp_h_q, sh_exp_h_d;
  logic [2:0]  err_q, err_d, err_set_s, err_clr_s;
  logic        frame_start_q, frame_start_d, frame_done_q, frame_done_d;
  logic        busy_q, busy_d;
  logic        vs_rise_s, vs_fall_s, hs_rise_s, hs_fall_s;
  logic [11:0] pix_cnt_s, line_cnt_s;
  logic        cfg_ready_s, wr_en_s;
  logic        unused_s;

  cfa_timing_mon u_mon (
    .clk      (clk),
    .reset    (reset),
    .in_vsync (in_vsync),
    .in_hsync (in_hsync),
    .in_den   (in_den),
    .state    (state_q),
    .vs_rise  (vs_rise_s),
    .vs_fall  (vs_fall_s),
    .hs_rise  (hs_rise_s),
    .hs_fall  (hs_fall_s),
    .pix_cnt  (pix_cnt_s),
    .line_cnt (line_cnt_s)
  );

  // Ready drops only in the commit cycle so shadow and active never race.
  assign cfg_ready_s   = ~vs_rise_s;
  assign cfg.cfg_ready = cfg_ready_s;
  assign wr_en_s       = cfg.cfg_valid & cfg_ready_s;
  assign unused_s      = ^cfg.cfg_wdata[15:12];

  assign cfa_raw_type = raw_q;
  assign cfa_bypass   = byp_q;
  assign frame_start  = frame_start_q;
  assign frame_done   = frame_done_q;
  assign err_hlen     = err_q[0];
  assign err_vlen     = err_q[1];
  assign err_trunc    = err_q[2];
  assign busy         = busy_q;

  // Next-state: config writes, commit on vsync rise, FSM and error detection.
  always_comb begin
    state_d       = state_q;
    raw_d         = raw_q;
    byp_d         = byp_q;
    exp_h_d       = exp_h_q;
    sh_raw_d      = sh_raw_q;
    sh_byp_d      = sh_byp_q;
    sh_exp_h_d    = sh_exp_h_q;
    err_set_s     = 3'b000;
    err_clr_s     = 3'b000;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;

    if (wr_en_s) begin
      case (cfg.cfg_addr)
        CFG_ADDR_RAW_TYPE: sh_raw_d   = cfg.cfg_wdata[1:0];
        CFG_ADDR_BYPASS:   sh_byp_d   = cfg.cfg_wdata[0];
        CFG_ADDR_EXP_H:    sh_exp_h_d = cfg.cfg_wdata[11:0];
        CFG_ADDR_ERR_CLR:  err_clr_s  = cfg.cfg_wdata[2:0];
        default:           err_clr_s  = 3'b000;
      endcase
    end else begin
      err_clr_s = 3'b000;
    end

    case (state_q)
      ST_IDLE: begin
        if (vs_rise_s) begin
          state_d       = ST_WAIT_LINE;
          frame_start_d = 1'b1;
          raw_d         = sh_raw_q;
          byp_d         = sh_byp_q;
          exp_h_d       = sh_exp_h_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_LINE: begin
        if (vs_fall_s) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          err_set_s[1] = (line_cnt_s != LINES_EXP);
        end else if (hs_rise_s) begin
          state_d = ST_LINE;
        end else begin
          state_d = ST_WAIT_LINE;
        end
      end
      ST_LINE: begin
        // A frame cut short mid-line skips the length checks entirely.
        if (vs_fall_s) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          err_set_s[2] = 1'b1;
        end else if (hs_fall_s) begin
          state_d      = ST_WAIT_LINE;
          err_set_s[0] = (pix_cnt_s != exp_h_q);
        end else begin
          state_d = ST_LINE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_d  = (err_q & ~err_clr_s) | err_set_s;
    busy_d = (state_d != ST_IDLE);
  end

  // Single register bank for state, config and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      raw_q         <= RAW_INIT;
      sh_raw_q      <= RAW_INIT;
      byp_q         <= 1'b0;
      sh_byp_q      <= 1'b0;
      exp_h_q       <= EXP_H_INIT;
      sh_exp_h_q    <= EXP_H_INIT;
      err_q         <= 3'b000;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      raw_q         <= raw_d;
      sh_raw_q      <= sh_raw_d;
      byp_q         <= byp_d;
      sh_byp_q      <= sh_byp_d;
      exp_h_q       <= exp_h_d;
      sh_exp_h_q    <= sh_exp_h_d;
      err_q         <= err_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

`ifdef CFA_CTRL_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

  // err_cnt counts cycles where at least one flag goes from clear to set.
  always_comb begin
    frame_cnt_d = frame_done_d ? (frame_cnt_q + 16'd1) : frame_cnt_q;
    if ((|(err_d & ~err_q)) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_cfa_ctrl.sv
// Scoreboard bench for cfa_ctrl: expected commit values and error flags are
// queued as frames are driven and compared when frame_start/frame_done pulse.
module tb_cfa_ctrl;
  import cfa_pkg::*;

  localparam int SH    = 16;
  localparam int SV    = 4;
  localparam int RINIT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_vsync, in_hsync, in_den;
  logic [1:0]  cfa_raw_type;
  logic        cfa_bypass, frame_start, frame_done;
  logic        err_hlen, err_vlen, err_trunc, busy;
`ifdef CFA_CTRL_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  cfa_ctrl_if cfg_bus ();

  cfa_ctrl #(.SOURCE_H(SH), .SOURCE_V(SV), .RAW_TYPE_INIT(RINIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_vsync     (in_vsync),
    .in_hsync     (in_hsync),
    .in_den       (in_den),
    .cfg          (cfg_bus.slave),
    .cfa_raw_type (cfa_raw_type),
    .cfa_bypass   (cfa_bypass),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .err_hlen     (err_hlen),
    .err_vlen     (err_vlen),
    .err_trunc    (err_trunc),
    .busy         (busy)
`ifdef CFA_CTRL_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  typedef struct packed { logic [1:0] raw; logic byp; } start_t;
  start_t     start_q[$];
  logic [2:0] done_q[$];
  start_t     mon_s;
  logic [2:0] mon_d;

  // Reference model state
  logic [1:0]  m_sh_raw, m_act_raw;
  logic        m_sh_byp, m_act_byp;
  logic [11:0] m_sh_exph, m_exph;
  logic [2:0]  m_err;
  int          m_frames;

  task automatic model_reset();
    m_sh_raw  = 2'(RINIT); m_act_raw = 2'(RINIT);
    m_sh_byp  = 1'b0;      m_act_byp = 1'b0;
    m_sh_exph = 12'(SH);   m_exph    = 12'(SH);
    m_err     = 3'b000;    m_frames  = 0;
  endtask

  // Output monitor: pops scoreboard entries on each pulse
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_start) begin
        if (start_q.size() == 0) check_val("start_unexpected", {31'd0, frame_start}, 32'd0);
        else begin
          mon_s = start_q.pop_front();
          check_val("start_raw", {30'd0, cfa_raw_type}, {30'd0, mon_s.raw});
          check_val("start_byp", {31'd0, cfa_bypass}, {31'd0, mon_s.byp});
        end
      end
      if (frame_done) begin
        if (done_q.size() == 0) check_val("done_unexpected", {31'd0, frame_done}, 32'd0);
        else begin
          mon_d = done_q.pop_front();
          check_val("done_errs", {29'd0, err_trunc, err_vlen, err_hlen}, {29'd0, mon_d});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic model_apply(input logic [1:0] a, input logic [15:0] d);
    case (a)
      2'd0: m_sh_raw  = d[1:0];
      2'd1: m_sh_byp  = d[0];
      2'd2: m_sh_exph = d[11:0];
      default: m_err  = m_err & ~d[2:0];
    endcase
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    logic acc;
    acc = 1'b0;
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_addr = a; cfg_bus.cfg_wdata = d;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk); acc = cfg_bus.cfg_ready;
      step();
    end
    cfg_bus.cfg_valid = 1'b0;
    if (!acc) check_val("cfg_accept_timeout", {31'd0, acc}, 32'd1);
    else model_apply(a, d);
  endtask

  task automatic vs_rise_cyc();
    start_t s;
    s.raw = m_sh_raw; s.byp = m_sh_byp;
    start_q.push_back(s);
    m_act_raw = m_sh_raw; m_act_byp = m_sh_byp; m_exph = m_sh_exph;
    in_vsync = 1'b1;
    @(negedge clk);
    check_val("ready_in_commit", {31'd0, cfg_bus.cfg_ready}, 32'd0);
    step();
    @(negedge clk);
    check_val("busy_in_frame", {31'd0, busy}, 32'd1);
    check_val("ready_after_commit", {31'd0, cfg_bus.cfg_ready}, 32'd1);
    step();
  endtask

  task automatic drive_line(input int n);
    in_hsync = 1'b1; step();
    for (int i = 0; i < n; i++) begin in_den = 1'b1; step(); end
    in_den = 1'b0; in_hsync = 1'b0;
    if (n != int'(m_exph)) m_err[0] = 1'b1;
    step(); step();
  endtask

  task automatic vs_fall_cyc(input int lines);
    if (lines != SV) m_err[1] = 1'b1;
    done_q.push_back(m_err);
    m_frames++;
    in_vsync = 1'b0; step();
    @(negedge clk);
    check_val("busy_after_frame", {31'd0, busy}, 32'd0);
    step();
  endtask

  task automatic run_frame(input int lines, input int den);
    vs_rise_cyc();
    for (int l = 0; l < lines; l++) drive_line(den);
    vs_fall_cyc(lines);
  endtask

  initial begin
    reset = 1'b1; in_vsync = 1'b0; in_hsync = 1'b0; in_den = 1'b0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_addr = 2'd0; cfg_bus.cfg_wdata = 16'd0;
    model_reset();
    step(); step();
    @(negedge clk);
    check_val("rst_raw", {30'd0, cfa_raw_type}, 32'd1);
    check_val("rst_byp", {31'd0, cfa_bypass}, 32'd0);
    check_val("rst_errs", {29'd0, err_trunc, err_vlen, err_hlen}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
    check_val("rst_pulses", {30'd0, frame_start, frame_done}, 32'd0);
    reset = 1'b0; step();

    // Idle hsync/den activity must not start anything
    in_hsync = 1'b1; in_den = 1'b1; step(); step();
    in_hsync = 1'b0; in_den = 1'b0; step();
    check_val("idle_busy", {31'd0, busy}, 32'd0);

    // Clean frame
    run_frame(SV, SH);

    // raw_type written mid-frame only commits at the next frame
    vs_rise_cyc();
    drive_line(SH);
    cfg_write(2'd0, 16'd2);
    drive_line(SH);
    @(negedge clk);
    check_val("raw_held_midframe", {30'd0, cfa_raw_type}, {30'd0, m_act_raw});
    step();
    drive_line(SH); drive_line(SH);
    vs_fall_cyc(SV);
    run_frame(SV, SH);

    // Short line -> err_hlen, then W1C
    vs_rise_cyc();
    drive_line(SH - 1);
    @(negedge clk);
    check_val("hlen_set", {31'd0, err_hlen}, 32'd1);
    step();
    for (int l = 1; l < SV; l++) drive_line(SH);
    vs_fall_cyc(SV);
    cfg_write(2'd3, 16'd1);
    @(negedge clk);
    check_val("hlen_cleared", {31'd0, err_hlen}, {31'd0, m_err[0]});
    step();

    // Missing line -> err_vlen
    run_frame(SV - 1, SH);
    cfg_write(2'd3, 16'd2);

    // Write held across the commit cycle lands one frame later
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_addr = 2'd0; cfg_bus.cfg_wdata = 16'd3;
    vs_rise_cyc();
    cfg_bus.cfg_valid = 1'b0;
    model_apply(2'd0, 16'd3);
    for (int l = 0; l < SV; l++) drive_line(SH);
    vs_fall_cyc(SV);
    cfg_write(2'd1, 16'd1);
    cfg_write(2'd2, 16'(SH - 2));
    run_frame(SV, SH - 2);
    run_frame(SV, SH - 2);

    // vsync drops mid-line -> err_trunc, no length checks
    vs_rise_cyc();
    drive_line(SH - 2);
    in_hsync = 1'b1; step();
    in_den = 1'b1; step(); step();
    m_err[2] = 1'b1;
    done_q.push_back(m_err);
    m_frames++;
    in_vsync = 1'b0; step();
    @(negedge clk);
    check_val("trunc_idle", {31'd0, busy}, 32'd0);
    check_val("trunc_flag", {31'd0, err_trunc}, 32'd1);
    step();
    in_hsync = 1'b0; in_den = 1'b0; step();
    cfg_write(2'd3, 16'd7);
    @(negedge clk);
    check_val("w1c_all", {29'd0, err_trunc, err_vlen, err_hlen}, {29'd0, m_err});
    step();

`ifdef CFA_CTRL_STATS_EN
    @(negedge clk);
    check_val("frame_cnt", {16'd0, frame_cnt}, m_frames);
    step();
`endif

    // Reset mid-line, released with vsync still high
    vs_rise_cyc();
    in_hsync = 1'b1; step();
    in_den = 1'b1; step(); step();
    reset = 1'b1; step();
    model_reset();
    @(negedge clk);
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_raw", {30'd0, cfa_raw_type}, 32'd1);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin in_hsync = ~in_hsync; step(); end
    @(negedge clk);
    check_val("post_rst_busy", {31'd0, busy}, 32'd0);
    step();
    in_hsync = 1'b0; in_den = 1'b0; in_vsync = 1'b0; step(); step();
    run_frame(SV, SH);

    repeat (3) step();
    check_val("start_queue_drained", start_q.size(), 32'd0);
    check_val("done_queue_drained", done_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfa_ctrl.md
CFA_CTRL -- requirements
Module: cfa_ctrl

Interface
REQ-001 SHALL have parameters: SOURCE_H, default 1024, expected active pixels per line; SOURCE_V, default 1024, expected lines per frame; RAW_TYPE_INIT, default 0, raw_type after reset (0 BGGR, 1 RGGB, 2 GBRG, 3 GRBG).
REQ-002 SHALL have one clock and an asynchronous, active-high reset; ports listed next, one per line (name, direction, width, meaning).
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_vsync / in_hsync / in_den  in  1 each  sensor timing monitored (high = active frame/line/pixel).
REQ-006 cfg_valid  in  1; cfg_ready  out  1; cfg_addr  in  2; cfg_wdata  in  16  host config write channel.
REQ-007 cfa_raw_type  out  2; cfa_bypass  out  1  active config driven to the demosaic datapath.
REQ-008 frame_start / frame_done  out  1 each  single-cycle pulses.
REQ-009 err_hlen / err_vlen / err_trunc  out  1 each  sticky timing errors.
REQ-010 busy  out  1  high while FSM not IDLE.

Function
REQ-011 Write accepted when cfg_valid && cfg_ready; addr 0 -> shadow raw_type = wdata[1:0], 1 -> shadow bypass = wdata[0], 2 -> shadow exp_h = wdata[11:0], 3 -> write-1-to-clear error flags (wdata[0] hlen, [1] vlen, [2] trunc), effective next cycle.
REQ-012 Shadow values SHALL reach active outputs only at commit, the cycle after an in_vsync rising edge; frame_start pulses that same cycle.
REQ-013 cfg_ready SHALL be 0 exactly in the cycle in_vsync rises (commit cycle), 1 otherwise; host holds cfg_valid until accepted.
REQ-014 FSM states: IDLE, WAIT_LINE, LINE.
REQ-015 IDLE -> WAIT_LINE on vsync rise; WAIT_LINE -> LINE on hsync rise; LINE -> WAIT_LINE on hsync fall; WAIT_LINE -> IDLE on vsync fall; LINE -> IDLE on vsync fall.
REQ-016 Pixel counter (12 bit) SHALL clear on hsync rise and increment per in_den=1 cycle in LINE, saturating at 4095.
REQ-017 On hsync fall, pixel count != active exp_h SHALL set err_hlen; line counter (12 bit, saturating) increments.
REQ-018 On vsync fall from WAIT_LINE, line count != SOURCE_V SHALL set err_vlen; frame_done pulses.
REQ-019 vsync fall while in LINE SHALL set err_trunc, pulse frame_done, skip hlen/vlen checks.
REQ-020 Error set and W1C in the same cycle: set wins.
REQ-021 hsync or in_den activity in IDLE SHALL be ignored; no counters move.
REQ-022 Latency: in_vsync rise at cycle N -> outputs updated and frame_start high at cycle N+1.

Reset
REQ-023 On reset: FSM IDLE; cfa_raw_type and shadow = RAW_TYPE_INIT; cfa_bypass and shadow = 0; exp_h active and shadow = SOURCE_H; counters 0; all error flags, pulses, busy = 0; cfg_ready = 1.
REQ-024 Reset asserted mid-frame SHALL abort with no frame_done; after release, FSM stays IDLE until the next vsync rise (a vsync already high is not a rise).

Configuration
REQ-025 Macro CFA_CTRL_STATS_EN defined: adds output frame_cnt (16 bit, wraps, +1 per frame_done) and err_cnt (8 bit, saturating at 255, +1 per cycle any error flag newly sets); both reset to 0. Undefined: both ports and counters absent, all other behaviour identical.

Structure
REQ-026 Shared package cfa_pkg SHALL hold the raw_type encoding constants, the FSM state enum, and the cfg address constants.
REQ-027 Sub-module cfa_timing_mon (edge detect + pixel/line counters) is natural; register/shadow/FSM sequencing stays in cfa_ctrl.

Verification
REQ-028 Write raw_type=2 mid-frame -> cfa_raw_type stays at the old value until the cycle after the next vsync rise, then reads 2.
REQ-029 cfg_valid held through a vsync rise cycle -> cfg_ready=0 that cycle, write accepted next cycle, takes effect the frame after.
REQ-030 Frame of SOURCE_V lines x SOURCE_H den each -> frame_done one pulse, no error flags.
REQ-031 One line with 1023 den (exp_h 1024) -> err_hlen=1 at that hsync fall; W1C addr3 wdata=1 clears it.
REQ-032 vsync drops mid-line -> err_trunc=1, frame_done pulses, FSM IDLE next cycle.
REQ-033 Reset asserted mid-LINE, then released with vsync high -> busy=0, no frame_start until vsync falls and rises again.
